dsp_mac_sched: RTL and testbench

Round-robin scheduler that shares one pipelined pre-add/multiply/post-add DSP slice (P = (D±B)·A ± C) between NREQ requesters. It accepts one operation per cycle through per-requester valid/ready handshakes and drives the slice's operand ports. It tracks each issued operation's requester ID through a tag pipeline matched to the slice latency, so every result returns tagged with its originator. It sits between the filter/MAC clients and the single shared DSP instance.

---
 rtl/dsp_mac_sched_pkg.sv | 19 +
 rtl/dsp_mac_sched_if.sv | 44 ++++
 rtl/dsp_mac_sched_rr_arbiter.sv | 35 +++
 rtl/dsp_mac_sched.sv | 116 +++++++++++
 tb/tb_dsp_mac_sched.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dsp_mac_sched_pkg.sv
// Shared definitions for the DSP-slice scheduler: operand widths, op encoding
// and the requester tag that follows each operation through the slice.
package dsp_mac_sched_pkg;

   localparam int AW = 18;
   localparam int CW = 48;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   // Wide enough for the largest supported requester count (8).
   localparam int TAG_IDW = 3;

   typedef struct packed {
      logic               valid;
      logic [TAG_IDW-1:0] id;
   } tag_t;

endpackage

// File: rtl/dsp_mac_sched_if.sv
// Requester, slice and result signals of the DSP scheduler; the scheduler
// connects through the slave modport, clients and slice through master.
interface dsp_mac_sched_if
   import dsp_mac_sched_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) ();

   // Handshake: requester i transfers its operands in the cycle where
   // req_valid[i] & req_ready[i]; operands stay stable while req_valid[i] is
   // high, and a requester may withdraw req_valid before it is granted.
   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ-1:0]    req_sub;
   logic [NREQ*AW-1:0] req_a;
   logic [NREQ*AW-1:0] req_b;
   logic [NREQ*AW-1:0] req_d;
   logic [NREQ*CW-1:0] req_c;

   logic [AW-1:0]      dsp_a;
   logic [AW-1:0]      dsp_b;
   logic [AW-1:0]      dsp_d;
   logic [CW-1:0]      dsp_c;
   logic               dsp_sub;
   logic [CW-1:0]      dsp_p;

   logic               res_valid;
   logic [IDW-1:0]     res_id;
   logic [CW-1:0]      res_p;

   modport slave (
      input  req_valid, req_sub, req_a, req_b, req_d, req_c, dsp_p,
      output req_ready, dsp_a, dsp_b, dsp_d, dsp_c, dsp_sub,
      output res_valid, res_id, res_p
   );

   modport master (
      output req_valid, req_sub, req_a, req_b, req_d, req_c, dsp_p,
      input  req_ready, dsp_a, dsp_b, dsp_d, dsp_c, dsp_sub,
      input  res_valid, res_id, res_p
   );

endinterface

// File: rtl/dsp_mac_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first set request at or above ptr,
// wrapping modulo NREQ. Purely combinational.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  idx
);

   int             j;
   logic [IDW-1:0] jj;

   // Scanning from the farthest candidate back to ptr lets the nearest
   // requester overwrite any earlier match.
   always_comb begin
      grant = '0;
      idx   = '0;
      j     = 0;
      jj    = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         j = int'(ptr) + k;
         if (j >= NREQ) j = j - NREQ;
         jj = IDW'(j);
         if (req[jj]) begin
            grant     = '0;
            grant[jj] = 1'b1;
            idx       = jj;
         end
      end
   end

endmodule

// File: rtl/dsp_mac_sched.sv
// Shares one pipelined (D+-B)*A+-C DSP slice among NREQ requesters with a
// tag pipeline that returns each result with its requester id.
// Optional build macro DSP_SCHED_PRIO0_EN gives requester 0 absolute priority.
module dsp_mac_sched
   import dsp_mac_sched_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int DSP_LAT = 5,
   parameter int IDW     = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  hold,
   dsp_mac_sched_if.slave        bus,
   output logic                  busy,
   output logic [4:0]            inflight
);

   logic [IDW-1:0]  rr_ptr;
   logic [IDW-1:0]  ptr_nxt;
   logic [NREQ-1:0] arb_req;
   logic [NREQ-1:0] rr_grant;
   logic [IDW-1:0]  rr_idx;
   logic [NREQ-1:0] grant;
   logic [IDW-1:0]  g;
   logic            hs;

   // Index 0 is the issue-stage tag; the slice latency adds DSP_LAT more.
   tag_t tag_q [DSP_LAT+1];

   always_comb begin
      arb_req = (hold || !rst_n) ? '0 : bus.req_valid;
`ifdef DSP_SCHED_PRIO0_EN
      arb_req[0] = 1'b0;
`endif
   end

   rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
      .req   (arb_req),
      .ptr   (rr_ptr),
      .grant (rr_grant),
      .idx   (rr_idx)
   );

   always_comb begin
      grant = rr_grant;
      g     = rr_idx;
`ifdef DSP_SCHED_PRIO0_EN
      if (!hold && rst_n && bus.req_valid[0]) begin
         grant = NREQ'(1);
         g     = '0;
      end
`endif
   end

   assign bus.req_ready = grant;
   assign hs            = |grant;

   always_comb begin
      ptr_nxt = rr_ptr;
      if (hs) ptr_nxt = (g == IDW'(NREQ - 1)) ? '0 : g + 1'b1;
`ifdef DSP_SCHED_PRIO0_EN
      // Requester 0 sits outside the rotation, so the pointer never lands on it.
      if (hs && g == '0) ptr_nxt = rr_ptr;
      else if (hs && ptr_nxt == '0) ptr_nxt = IDW'(1);
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr      <= '0;
         bus.dsp_a   <= '0;
         bus.dsp_b   <= '0;
         bus.dsp_d   <= '0;
         bus.dsp_c   <= '0;
         bus.dsp_sub <= OP_ADD;
      end else begin
         rr_ptr <= ptr_nxt;
         if (hs) begin
            bus.dsp_a   <= bus.req_a[int'(g)*AW +: AW];
            bus.dsp_b   <= bus.req_b[int'(g)*AW +: AW];
            bus.dsp_d   <= bus.req_d[int'(g)*AW +: AW];
            bus.dsp_c   <= bus.req_c[int'(g)*CW +: CW];
            bus.dsp_sub <= bus.req_sub[g];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i <= DSP_LAT; i++) tag_q[i] <= '0;
      end else begin
         tag_q[0] <= '{valid: hs, id: TAG_IDW'(g)};
         for (int i = 1; i <= DSP_LAT; i++) tag_q[i] <= tag_q[i-1];
      end
   end

   assign bus.res_valid = tag_q[DSP_LAT].valid;
   assign bus.res_id    = IDW'(tag_q[DSP_LAT].id);
   assign bus.res_p     = bus.dsp_p;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight <= '0;
      end else begin
         case ({hs, bus.res_valid})
            2'b10:   inflight <= inflight + 5'd1;
            2'b01:   inflight <= inflight - 5'd1;
            default: inflight <= inflight;
         endcase
      end
   end

   assign busy = (|inflight) | hs;

endmodule

// File: tb/tb_dsp_mac_sched.sv
// Self-checking bench for dsp_mac_sched with an ideal 5-cycle DSP slice model.
module tb_dsp_mac_sched;
   import dsp_mac_sched_pkg::*;

   localparam int NREQ    = 4;
   localparam int DSP_LAT = 5;
   localparam int IDW     = 2;

   logic       clk;
   logic       rst_n;
   logic       hold;
   logic       busy;
   logic [4:0] inflight;

   dsp_mac_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

   dsp_mac_sched #(.NREQ(NREQ), .DSP_LAT(DSP_LAT), .IDW(IDW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .hold     (hold),
      .bus      (bus.slave),
      .busy     (busy),
      .inflight (inflight)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- ideal slice model ----------------
   function automatic logic [47:0] dsp_fn(input logic [17:0] a, input logic [17:0] b,
                                          input logic [17:0] d, input logic [47:0] c,
                                          input logic sub);
      longint la, lb, ld, lc, r;
      la = longint'($signed(a));
      lb = longint'($signed(b));
      ld = longint'($signed(d));
      lc = longint'($signed(c));
      r  = sub ? (ld - lb) * la - lc : (ld + lb) * la + lc;
      return r[47:0];
   endfunction

   logic [47:0] p_pipe [DSP_LAT];
   always @(posedge clk) begin
      p_pipe[0] <= dsp_fn(bus.dsp_a, bus.dsp_b, bus.dsp_d, bus.dsp_c, bus.dsp_sub);
      for (int i = 1; i < DSP_LAT; i++) p_pipe[i] <= p_pipe[i-1];
   end
   assign bus.dsp_p = p_pipe[DSP_LAT-1];

   // ---------------- requester operands ----------------
   logic [17:0] op_a [NREQ];
   logic [17:0] op_b [NREQ];
   logic [17:0] op_d [NREQ];
   logic [47:0] op_c [NREQ];
   logic        op_sub [NREQ];

   task automatic set_op(input int i, input logic [17:0] a, input logic [17:0] b,
                         input logic [17:0] d, input logic [47:0] c, input logic sub);
      op_a[i] = a; op_b[i] = b; op_d[i] = d; op_c[i] = c; op_sub[i] = sub;
   endtask

   task automatic rand_op(input int i);
      set_op(i, 18'($urandom), 18'($urandom), 18'($urandom),
             {16'($urandom), 32'($urandom)}, 1'($urandom_range(0, 1)));
   endtask

   task automatic pack_ops();
      for (int i = 0; i < NREQ; i++) begin
         bus.req_a[18*i +: 18] = op_a[i];
         bus.req_b[18*i +: 18] = op_b[i];
         bus.req_d[18*i +: 18] = op_d[i];
         bus.req_c[48*i +: 48] = op_c[i];
         bus.req_sub[i]        = op_sub[i];
      end
   endtask

   // ---------------- reference model + scoreboard ----------------
   typedef struct packed {
      int             due;
      logic [IDW-1:0] id;
      logic [47:0]    p;
   } exp_t;

   exp_t exp_q[$];
   int   m_ptr;
   int   cyc;
   int   total;
   int   bad;

   logic [NREQ-1:0] last_rdy;
   logic            last_rv;
   logic [IDW-1:0]  last_id;
   logic [47:0]     last_p;
   logic [4:0]      last_inf;

   function automatic int model_grant(input logic [NREQ-1:0] v, input logic h, input int ptr);
      int j;
      if (h) return -1;
`ifdef DSP_SCHED_PRIO0_EN
      if (v[0]) return 0;
`endif
      for (int k = 0; k < NREQ; k++) begin
         j = (ptr + k) % NREQ;
`ifdef DSP_SCHED_PRIO0_EN
         if (j != 0 && v[j]) return j;
`else
         if (v[j]) return j;
`endif
      end
      return -1;
   endfunction

   function automatic int model_next(input int gi, input int ptr);
`ifdef DSP_SCHED_PRIO0_EN
      if (gi == 0) return ptr;
      return ((gi + 1) % NREQ == 0) ? 1 : (gi + 1) % NREQ;
`else
      if (ptr < 0) return 0;
      return (gi + 1) % NREQ;
`endif
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // One clock cycle: drive, compare against the model, advance.
   task automatic step(input logic [NREQ-1:0] v, input logic h);
      int              gi;
      logic [NREQ-1:0] er;
      exp_t            e;
      bus.req_valid = v;
      hold          = h;
      pack_ops();
      #1;
      gi = model_grant(v, h, m_ptr);
      er = '0;
      if (gi >= 0) er = NREQ'(1) << gi;
      last_rdy = bus.req_ready;
      last_rv  = bus.res_valid;
      last_id  = bus.res_id;
      last_p   = bus.res_p;
      last_inf = inflight;
      check("req_ready", 64'(bus.req_ready), 64'(er));
      check("inflight", 64'(inflight), 64'(exp_q.size()));
      check("busy", 64'(busy), 64'((exp_q.size() > 0) || (gi >= 0)));
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
         e = exp_q.pop_front();
         check("res_valid", 64'(bus.res_valid), 64'(1));
         check("res_id", 64'(bus.res_id), 64'(e.id));
         check("res_p", 64'(bus.res_p), 64'(e.p));
      end else begin
         check("res_valid", 64'(bus.res_valid), 64'(0));
      end
      if (gi >= 0) begin
         e.due = cyc + DSP_LAT + 1;
         e.id  = IDW'(gi);
         e.p   = dsp_fn(op_a[gi], op_b[gi], op_d[gi], op_c[gi], op_sub[gi]);
         exp_q.push_back(e);
         m_ptr = model_next(gi, m_ptr);
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n         = 1'b0;
      hold          = 1'b0;
      bus.req_valid = '0;
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
      m_ptr = 0;
   endtask

   typedef struct {
      logic [NREQ-1:0] v;
      logic            h;
      logic [NREQ-1:0] rdy;
   } vec_t;

   vec_t            tbl [12];
   int              lat;
   int              peak;
   int              pulses;
   logic [IDW-1:0]  rid;
   logic [47:0]     rp;
   logic [NREQ-1:0] cur_v;
   logic [NREQ-1:0] nv;

   initial begin
      // Round-robin walk from pointer 0, including a 3-cycle hold window.
      tbl[0]  = '{4'b1111, 1'b0, 4'b0001};
      tbl[1]  = '{4'b1111, 1'b0, 4'b0010};
      tbl[2]  = '{4'b1111, 1'b1, 4'b0000};
      tbl[3]  = '{4'b1111, 1'b1, 4'b0000};
      tbl[4]  = '{4'b1111, 1'b1, 4'b0000};
      tbl[5]  = '{4'b1111, 1'b0, 4'b0100};
      tbl[6]  = '{4'b0011, 1'b0, 4'b0001};
      tbl[7]  = '{4'b1000, 1'b0, 4'b1000};
      tbl[8]  = '{4'b0000, 1'b0, 4'b0000};
      tbl[9]  = '{4'b0110, 1'b0, 4'b0010};
      tbl[10] = '{4'b0010, 1'b0, 4'b0010};
      tbl[11] = '{4'b1001, 1'b0, 4'b1000};

      total = 0; bad = 0; cyc = 0; m_ptr = 0;
      rst_n = 1'b0; hold = 1'b0; bus.req_valid = '0;
      for (int i = 0; i < NREQ; i++) set_op(i, '0, '0, '0, '0, OP_ADD);
      pack_ops();
      repeat (3) @(negedge clk);
      bus.req_valid = 4'b1111;
      #1;
      check("rst_req_ready", 64'(bus.req_ready), 64'(0));
      check("rst_res_valid", 64'(bus.res_valid), 64'(0));
      check("rst_res_id", 64'(bus.res_id), 64'(0));
      check("rst_inflight", 64'(inflight), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_dsp_a", 64'(bus.dsp_a), 64'(0));
      check("rst_dsp_c", 64'(bus.dsp_c), 64'(0));
      check("rst_dsp_sub", 64'(bus.dsp_sub), 64'(0));
      bus.req_valid = '0;
      @(negedge clk);
      rst_n = 1'b1;

      // Single ADD from requester 1: (5+2)*3+10 = 31 after 6 cycles.
      set_op(1, 18'd3, 18'd2, 18'd5, 48'd10, OP_ADD);
      step(4'b0010, 1'b0);
      lat = -1; rid = '0; rp = '0;
      for (int i = 1; i <= 10; i++) begin
         step(4'b0000, 1'b0);
         if (last_rv && lat < 0) begin lat = i; rid = last_id; rp = last_p; end
      end
      check("add_latency", 64'(lat), 64'(6));
      check("add_id", 64'(rid), 64'(1));
      check("add_p", 64'(rp), 64'(31));

      // SUB from requester 2: (3-7)*4-1 = -17.
      set_op(2, 18'd4, 18'd7, 18'd3, 48'd1, OP_SUB);
      step(4'b0100, 1'b0);
      lat = -1;
      for (int i = 1; i <= 10; i++) begin
         step(4'b0000, 1'b0);
         if (last_rv && lat < 0) begin lat = i; rid = last_id; rp = last_p; end
      end
      check("sub_latency", 64'(lat), 64'(6));
      check("sub_id", 64'(rid), 64'(2));
      check("sub_p", 64'(rp), 64'(48'hFFFF_FFFF_FFEF));

      // All requesters continuously valid.
      do_reset();
      for (int i = 0; i < NREQ; i++) rand_op(i);
      peak = 0;
      for (int i = 0; i < 16; i++) begin
         step(4'b1111, 1'b0);
`ifndef DSP_SCHED_PRIO0_EN
         check("rr_order", 64'(last_rdy), 64'(1 << (i % 4)));
`endif
         if (int'(last_inf) > peak) peak = int'(last_inf);
         for (int r = 0; r < NREQ; r++) if (last_rdy[r]) rand_op(r);
      end
      repeat (8) step(4'b0000, 1'b0);
      check("inflight_peak", 64'(peak), 64'(6));

      do_reset();
`ifdef DSP_SCHED_PRIO0_EN
      for (int i = 0; i < 3; i++) begin
         step(4'b1001, 1'b0);
         check("prio0_hold", 64'(last_rdy), 64'(4'b0001));
      end
      step(4'b1000, 1'b0);
      check("prio0_drop", 64'(last_rdy), 64'(4'b1000));
`else
      for (int i = 0; i < 12; i++) begin
         step(tbl[i].v, tbl[i].h);
         check("tbl_ready", 64'(last_rdy), 64'(tbl[i].rdy));
      end
`endif
      repeat (8) step(4'b0000, 1'b0);

      // Asynchronous reset with 4 ops in flight.
      do_reset();
      for (int i = 0; i < 4; i++) step(4'b1111, 1'b0);
      check("pre_rst_inflight", 64'(inflight), 64'(4));
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_req_ready", 64'(bus.req_ready), 64'(0));
      check("mid_rst_res_valid", 64'(bus.res_valid), 64'(0));
      check("mid_rst_inflight", 64'(inflight), 64'(0));
      check("mid_rst_busy", 64'(busy), 64'(0));
      check("mid_rst_dsp_a", 64'(bus.dsp_a), 64'(0));
      bus.req_valid = '0;
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
      m_ptr  = 0;
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         step(4'b0000, 1'b0);
         if (last_rv) pulses++;
      end
      check("post_rst_pulses", 64'(pulses), 64'(0));

      // Randomized traffic against the model.
      cur_v = '0;
      last_rdy = '0;
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < NREQ; i++) if (!cur_v[i] || last_rdy[i]) rand_op(i);
         nv = NREQ'($urandom_range(0, 15));
         step(nv, ($urandom_range(0, 9) == 0));
         cur_v = nv;
      end
      repeat (10) step(4'b0000, 1'b0);
      check("drained", 64'(exp_q.size()), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
